uart_tx_serializer: RTL and testbench

//   Transmit half of the UART path: accepts one byte per handshake and drives an
//   8-bit, LSB-first asynchronous frame on tx (start, 8 data, [parity], stop).

---
 rtl/uart_tx_serializer.sv | 151 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: 8-bit LSB-first frame (start, data, [parity], stop) with its own bit timer.
// Latency: tx goes low the cycle after accept; frame lasts D*(10+STOP_BITS-1) cycles (+D with parity).
// Backpressure: tx_ready only in IDLE; tx_valid while busy is ignored. Optional parity: UART_TX_PARITY_EN.
module uart_tx_serializer #(
    parameter int          DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 5208,
    parameter int          STOP_BITS   = 1
) (
    input  logic                 clock,
    input  logic                 init_flag,
    input  logic                 baud_div_load,
    input  logic [DIV_WIDTH-1:0] baud_div_value,
    input  logic                 tx_valid,
    input  logic [7:0]           tx_data,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] shadow_q;
    logic [DIV_WIDTH-1:0] shadow_d;
    logic [DIV_WIDTH-1:0] last_q;
    logic [DIV_WIDTH-1:0] last_d;
    logic [DIV_WIDTH-1:0] timer_q;
    logic [7:0]           shift_q;
    logic [2:0]           bit_idx_q;
    logic                 stop_cnt_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 done_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic accept;
    logic bit_wrap;

    // A load on the accept edge must reach the captured divisor, so capture from shadow_d.
    assign shadow_d = baud_div_load ? baud_div_value : shadow_q;
    assign last_d   = (shadow_d == '0) ? '0 : shadow_d - DIV_WIDTH'(1);
    assign accept   = tx_valid && ready_q;
    assign bit_wrap = (timer_q == last_q);

    always_ff @(posedge clock or negedge init_flag) begin
        if (!init_flag) begin
            state_q    <= S_IDLE;
            shadow_q   <= DIV_WIDTH'(DEFAULT_DIV);
            last_q     <= '0;
            timer_q    <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            shadow_q <= shadow_d;
            done_q   <= 1'b0;
            if (state_q == S_IDLE) begin
                if (accept) begin
                    state_q    <= S_START;
                    last_q     <= last_d;
                    timer_q    <= '0;
                    shift_q    <= tx_data;
                    bit_idx_q  <= '0;
                    stop_cnt_q <= 1'b0;
                    tx_q       <= 1'b0;
                    ready_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_q   <= (^tx_data) ^ parity_odd;
`endif
                end
            end else if (!bit_wrap) begin
                timer_q <= timer_q + DIV_WIDTH'(1);
            end else begin
                timer_q <= '0;
                case (state_q)
                    S_START: begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end
                    S_DATA: begin
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
`endif
                    S_STOP: begin
                        if (stop_cnt_q == STOP_LAST) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = ~ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: directed frames plus randomized frames checked cycle by cycle
// against an expected bit list built from the frame format and the bench's own divisor model.
module tb_uart_tx_serializer;

    localparam int DW      = 16;
    localparam int DEF_DIV = 7;
    localparam int SB      = 1;

    logic          clock = 1'b0;
    logic          init_flag = 1'b0;
    logic          baud_div_load = 1'b0;
    logic [DW-1:0] baud_div_value = '0;
    logic          tx_valid = 1'b0;
    logic [7:0]    tx_data = '0;
`ifdef UART_TX_PARITY_EN
    logic          parity_odd = 1'b0;
`endif
    logic          tx_ready;
    logic          tx_busy;
    logic          tx_done;
    logic          tx;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] m_shadow = DW'(DEF_DIV);

    uart_tx_serializer #(
        .DIV_WIDTH  (DW),
        .DEFAULT_DIV(DEF_DIV),
        .STOP_BITS  (SB)
    ) dut (
        .clock         (clock),
        .init_flag     (init_flag),
        .baud_div_load (baud_div_load),
        .baud_div_value(baud_div_value),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
`ifdef UART_TX_PARITY_EN
        .parity_odd    (parity_odd),
`endif
        .tx_ready      (tx_ready),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx            (tx)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [DW-1:0] val);
        baud_div_load  = 1'b1;
        baud_div_value = val;
        tick();
        baud_div_load  = 1'b0;
        m_shadow       = val;
    endtask

    // Sends one byte and checks every frame cycle; returns positioned in the tx_done cycle.
    task automatic send(input logic [7:0] d, input bit podd, input bit hold, input int mid_at,
                        input logic [DW-1:0] mid_val, input bit acc_load, input logic [DW-1:0] acc_val);
        bit exp_bits[$];
        int n;
        int dd;
        int c;
        n = 0;
        while (!tx_ready && n < 300) begin
            tick();
            n++;
        end
        check_eq("accept_ready", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
`ifdef UART_TX_PARITY_EN
        parity_odd = podd;
`endif
        if (acc_load) begin
            baud_div_load  = 1'b1;
            baud_div_value = acc_val;
            m_shadow       = acc_val;
        end
        dd = (m_shadow == 0) ? 1 : int'(m_shadow);
        exp_bits = {1'b0};
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back((^d) ^ podd);
`endif
        for (int s = 0; s < SB; s++) exp_bits.push_back(1'b1);
        tick();
        baud_div_load = 1'b0;
        if (!hold) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
        c = 1;
        foreach (exp_bits[b]) begin
            for (int k = 0; k < dd; k++) begin
                check_eq("tx_bit", tx, exp_bits[b]);
                check_eq("ready_in_frame", tx_ready, 0);
                check_eq("busy_in_frame", tx_busy, 1);
                check_eq("done_in_frame", tx_done, 0);
                if (c == mid_at) begin
                    baud_div_load  = 1'b1;
                    baud_div_value = mid_val;
                    m_shadow       = mid_val;
                end else begin
                    baud_div_load = 1'b0;
                end
                tick();
                c++;
            end
        end
        baud_div_load = 1'b0;
        check_eq("done_pulse", tx_done, 1);
        check_eq("ready_after_frame", tx_ready, 1);
        check_eq("busy_after_frame", tx_busy, 0);
        check_eq("idle_tx", tx, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=%0d exp=%0d", n_checks, -1);
        $fatal(1, "bench timeout");
    end

    initial begin
        bit prev_hold;
        bit hold;
        int mid_at;

        #12;
        check_eq("reset_tx", tx, 1);
        check_eq("reset_ready", tx_ready, 1);
        check_eq("reset_busy", tx_busy, 0);
        check_eq("reset_done", tx_done, 0);
        #1 init_flag = 1'b1;
        tick();

        // Default divisor after reset
        send(8'h5A, 1'b0, 1'b0, -1, '0, 1'b0, '0);

        // div=4, 0xA5, then tx_done must be a single-cycle pulse
        do_load(16'd4);
        send(8'hA5, 1'b0, 1'b0, -1, '0, 1'b0, '0);
        tick();
        check_eq("done_one_cycle", tx_done, 0);

        // Back-to-back with valid held, div=2
        do_load(16'd2);
        send(8'h00, 1'b0, 1'b1, -1, '0, 1'b0, '0);
        send(8'hFF, 1'b0, 1'b0, -1, '0, 1'b0, '0);

        // Load during DATA: frame keeps 4, next frame uses 8
        do_load(16'd4);
        send(8'hA5, 1'b0, 1'b0, 10, 16'd8, 1'b0, '0);
        send(8'h3C, 1'b0, 1'b0, -1, '0, 1'b0, '0);

        // Load on the accept edge wins
        send(8'h81, 1'b0, 1'b0, -1, '0, 1'b1, 16'd3);

        // Divisor 0 behaves as 1
        do_load(16'd0);
        send(8'h01, 1'b0, 1'b0, -1, '0, 1'b0, '0);

`ifdef UART_TX_PARITY_EN
        do_load(16'd4);
        send(8'hA5, 1'b0, 1'b0, -1, '0, 1'b0, '0);
        send(8'hA5, 1'b1, 1'b0, -1, '0, 1'b0, '0);
`endif

        // Async reset mid-DATA
        do_load(16'd4);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (12) tick();
        #3 init_flag = 1'b0;
        #1;
        check_eq("arst_tx", tx, 1);
        check_eq("arst_ready", tx_ready, 1);
        check_eq("arst_busy", tx_busy, 0);
        check_eq("arst_done", tx_done, 0);
        tick();
        #2 init_flag = 1'b1;
        m_shadow = DW'(DEF_DIV);
        tick();
        for (int i = 0; i < 40; i++) begin
            check_eq("no_done_after_rst", tx_done, 0);
            check_eq("idle_after_rst", tx, 1);
            tick();
        end
        send(8'h96, 1'b0, 1'b0, -1, '0, 1'b0, '0);

        // Randomized frames
        prev_hold = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (!prev_hold && ($urandom % 2 == 0))
                do_load(DW'($urandom_range(0, 5)));
            hold   = (i < 24) && ($urandom % 3 == 0);
            mid_at = ($urandom % 3 == 0) ? int'($urandom_range(1, 9)) : -1;
            send(8'($urandom), 1'($urandom), hold, mid_at, DW'($urandom_range(0, 5)),
                 ($urandom % 4 == 0), DW'($urandom_range(0, 5)));
            prev_hold = hold;
        end
        tx_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
